// File: rtl/timer_pkg.sv
// Shared types and defaults for the prescaled timer bank.
// Optional input capture is enabled by defining TIMER_CAPTURE_EN.
package timer_pkg;
  localparam int TIMER_BITS_DEFAULT = 32;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tmr_state_t;
endpackage

// File: rtl/timer_channel.sv
// One prescaled timer channel: prescaler, tick counter, expiry/irq and optional capture.
// TIMER_CAPTURE_EN adds capture_in/capture_val/capture_stb.
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | halted after reset or stop; cnt holds
// ST_RUN  | counting prescaled ticks while enable is high
// ST_DONE | one-shot reached terminal count; cnt holds
module timer_channel
  import timer_pkg::*;
#(
  parameter int TIMER_BITS = TIMER_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  mode_t                 mode,
  input  logic [TIMER_BITS-1:0] prescaler,
  input  logic [TIMER_BITS-1:0] period,
  input  logic                  irq_clr,
`ifdef TIMER_CAPTURE_EN
  input  logic                  capture_in,
  output logic [TIMER_BITS-1:0] capture_val,
  output logic                  capture_stb,
`endif
  output logic [TIMER_BITS-1:0] cnt,
  output logic                  tick,
  output logic                  expire,
  output logic                  busy,
  output logic                  irq
);

  tmr_state_t            state, state_nxt;
  logic [TIMER_BITS-1:0] pc, pc_nxt, cnt_nxt;
  logic                  tick_nxt, expire_nxt, irq_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      cnt    <= '0;
      tick   <= 1'b0;
      expire <= 1'b0;
      irq    <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      cnt    <= cnt_nxt;
      tick   <= tick_nxt;
      expire <= expire_nxt;
      irq    <= irq_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    cnt_nxt    = cnt;
    tick_nxt   = 1'b0;
    expire_nxt = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (start) begin
      state_nxt = ST_RUN;
      pc_nxt    = '0;
      cnt_nxt   = '0;
    end else if (state == ST_RUN && enable) begin
      if (pc == prescaler) begin
        pc_nxt   = '0;
        tick_nxt = 1'b1;
        // >= so a period lowered below cnt expires on this tick instead of running away
        if (cnt >= period) begin
          expire_nxt = 1'b1;
          if (mode == MODE_PERIODIC) cnt_nxt = '0;
          else                       state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + TIMER_BITS'(1);
        end
      end else begin
        pc_nxt = pc + TIMER_BITS'(1);
      end
    end
    irq_nxt = expire_nxt | (irq & ~irq_clr);
  end

  assign busy = (state == ST_RUN);

`ifdef TIMER_CAPTURE_EN
  logic cap_hist;
  logic cap_edge;

  assign cap_edge = capture_in & ~cap_hist;

  // cnt here is the pre-update register value, so a coincident count step is not seen
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_hist    <= 1'b0;
      capture_val <= '0;
      capture_stb <= 1'b0;
    end else begin
      cap_hist    <= capture_in;
      capture_stb <= cap_edge;
      if (cap_edge) capture_val <= cnt;
    end
  end
`endif

endmodule

// File: rtl/prescaled_timer_bank.sv
// Bank of CHANNELS independent prescaled timers with a combined interrupt.
// TIMER_CAPTURE_EN adds per-channel input capture ports.
module prescaled_timer_bank
  import timer_pkg::*;
#(
  parameter int TIMER_BITS = TIMER_BITS_DEFAULT,
  parameter int CHANNELS   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS-1:0]                 enable,
  input  logic [CHANNELS-1:0]                 start,
  input  logic [CHANNELS-1:0]                 stop,
  input  logic [CHANNELS-1:0]                 mode,
  input  logic [CHANNELS-1:0][TIMER_BITS-1:0] prescaler,
  input  logic [CHANNELS-1:0][TIMER_BITS-1:0] period,
  input  logic [CHANNELS-1:0]                 irq_clr,
`ifdef TIMER_CAPTURE_EN
  input  logic [CHANNELS-1:0]                 capture_in,
  output logic [CHANNELS-1:0][TIMER_BITS-1:0] capture_val,
  output logic [CHANNELS-1:0]                 capture_stb,
`endif
  output logic [CHANNELS-1:0][TIMER_BITS-1:0] cnt,
  output logic [CHANNELS-1:0]                 tick,
  output logic [CHANNELS-1:0]                 expire,
  output logic [CHANNELS-1:0]                 busy,
  output logic [CHANNELS-1:0]                 irq,
  output logic                                irq_any
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(.TIMER_BITS(TIMER_BITS)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable[i]),
      .start      (start[i]),
      .stop       (stop[i]),
      .mode       (mode_t'(mode[i])),
      .prescaler  (prescaler[i]),
      .period     (period[i]),
      .irq_clr    (irq_clr[i]),
`ifdef TIMER_CAPTURE_EN
      .capture_in (capture_in[i]),
      .capture_val(capture_val[i]),
      .capture_stb(capture_stb[i]),
`endif
      .cnt        (cnt[i]),
      .tick       (tick[i]),
      .expire     (expire[i]),
      .busy       (busy[i]),
      .irq        (irq[i])
    );
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_prescaled_timer_bank.sv
// Directed self-checking bench for prescaled_timer_bank (4 channels, 32-bit).
// Capture checks are included when TIMER_CAPTURE_EN is defined.
module tb_prescaled_timer_bank;
  localparam int TB = 32;
  localparam int CH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CH-1:0]         enable, start, stop, mode, irq_clr;
  logic [CH-1:0][TB-1:0] prescaler, period;
  logic [CH-1:0][TB-1:0] cnt;
  logic [CH-1:0]         tick, expire, busy, irq;
  logic                  irq_any;
`ifdef TIMER_CAPTURE_EN
  logic [CH-1:0]         capture_in;
  logic [CH-1:0][TB-1:0] capture_val;
  logic [CH-1:0]         capture_stb;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  prescaled_timer_bank #(.TIMER_BITS(TB), .CHANNELS(CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .prescaler  (prescaler),
    .period     (period),
    .irq_clr    (irq_clr),
`ifdef TIMER_CAPTURE_EN
    .capture_in (capture_in),
    .capture_val(capture_val),
    .capture_stb(capture_stb),
`endif
    .cnt        (cnt),
    .tick       (tick),
    .expire     (expire),
    .busy       (busy),
    .irq        (irq),
    .irq_any    (irq_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1ns after the active edge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; enable = '0; start = '0; stop = '0; mode = '0; irq_clr = '0;
    prescaler = '0; period = '0;
`ifdef TIMER_CAPTURE_EN
    capture_in = '0;
`endif
    step(2);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("rst_cnt%0d", c), cnt[c], 0);
    end
    chk("rst_tick", {28'd0, tick}, 0);
    chk("rst_expire", {28'd0, expire}, 0);
    chk("rst_busy", {28'd0, busy}, 0);
    chk("rst_irq", {28'd0, irq}, 0);
    chk("rst_irq_any", {31'd0, irq_any}, 0);
    rst = 1'b0;

    prescaler[0] = 0; period[0] = 3; mode[0] = 1'b1;
    prescaler[1] = 2; period[1] = 1; mode[1] = 1'b0;
    prescaler[2] = 1; period[2] = 1; mode[2] = 1'b1;
    prescaler[3] = 0; period[3] = 9; mode[3] = 1'b1;
    enable = '1;

    // ch0 periodic P=0 M=3
    start[0] = 1'b1; step(); start[0] = 1'b0;
    chk("p0_busy_rise", {31'd0, busy[0]}, 1);
    chk("p0_cnt_start", cnt[0], 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("p0_expire_e%0d", k), {31'd0, expire[0]}, (k % 4 == 0) ? 1 : 0);
      chk($sformatf("p0_cnt_e%0d", k), cnt[0], k % 4);
      chk($sformatf("p0_tick_e%0d", k), {31'd0, tick[0]}, 1);
    end
    chk("p0_irq", {31'd0, irq[0]}, 1);
    step();
    stop[0] = 1'b1; step(); stop[0] = 1'b0;
    chk("stop_busy", {31'd0, busy[0]}, 0);
    chk("stop_cnt_hold", cnt[0], 1);
    step(3);
    chk("stop_cnt_later", cnt[0], 1);
    chk("stop_no_tick", {31'd0, tick[0]}, 0);

    // ch1 one-shot P=2 M=1 concurrently with ch2 periodic P=1 M=1
    start[1] = 1'b1; start[2] = 1'b1; step(); start[1] = 1'b0; start[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("os_tick_e%0d", k), {31'd0, tick[1]}, (k % 3 == 0 && k <= 6) ? 1 : 0);
      chk($sformatf("os_expire_e%0d", k), {31'd0, expire[1]}, (k == 6) ? 1 : 0);
      chk($sformatf("os_busy_e%0d", k), {31'd0, busy[1]}, (k < 6) ? 1 : 0);
      chk($sformatf("os_cnt_e%0d", k), cnt[1], (k < 3) ? 0 : 1);
      chk($sformatf("c2_expire_e%0d", k), {31'd0, expire[2]}, (k % 4 == 0) ? 1 : 0);
      chk($sformatf("c2_cnt_e%0d", k), cnt[2], (k % 4) / 2);
      chk($sformatf("c2_tick_e%0d", k), {31'd0, tick[2]}, (k % 2 == 0) ? 1 : 0);
    end
    stop[2] = 1'b1; step(); stop[2] = 1'b0;
    irq_clr[2:0] = 3'b111; step(); irq_clr = '0;
    chk("clr_irq", {28'd0, irq}, 0);
    chk("clr_irq_any", {31'd0, irq_any}, 0);

    // ch3 P=0 M=9, period lowered to 2 at cnt=5
    start[3] = 1'b1; step(); start[3] = 1'b0;
    step(5);
    chk("low_cnt5", cnt[3], 5);
    period[3] = 2;
    step();
    chk("low_expire", {31'd0, expire[3]}, 1);
    chk("low_cnt0", cnt[3], 0);
    chk("low_irq", {31'd0, irq[3]}, 1);
    chk("low_irq_any", {31'd0, irq_any}, 1);
    step();
    chk("low_cnt1", cnt[3], 1);

    enable[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("frz_cnt%0d", k), cnt[3], 1);
      chk($sformatf("frz_tick%0d", k), {31'd0, tick[3]}, 0);
      chk($sformatf("frz_busy%0d", k), {31'd0, busy[3]}, 1);
    end
    enable[3] = 1'b1;
    irq_clr[3] = 1'b1; step();
    chk("clr3_irq", {31'd0, irq[3]}, 0);
    chk("clr3_cnt", cnt[3], 2);
    step();
    irq_clr[3] = 1'b0;
    chk("setwin_expire", {31'd0, expire[3]}, 1);
    chk("setwin_irq", {31'd0, irq[3]}, 1);
    chk("setwin_cnt", cnt[3], 0);
    step();
    start[3] = 1'b1; stop[3] = 1'b1; step(); start[3] = 1'b0; stop[3] = 1'b0;
    chk("ss_busy", {31'd0, busy[3]}, 0);
    chk("ss_cnt", cnt[3], 1);

    // mid-run reset with a coincident start
    start[0] = 1'b1; step(); start[0] = 1'b0;
    step(2);
    chk("mr_cnt_pre", cnt[0], 2);
    rst = 1'b1; start[1] = 1'b1; step(); rst = 1'b0; start[1] = 1'b0;
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("mr_cnt%0d", c), cnt[c], 0);
    end
    chk("mr_busy", {28'd0, busy}, 0);
    chk("mr_tick", {28'd0, tick}, 0);
    chk("mr_expire", {28'd0, expire}, 0);
    chk("mr_irq", {28'd0, irq}, 0);
    chk("mr_irq_any", {31'd0, irq_any}, 0);

`ifdef TIMER_CAPTURE_EN
    period[0] = 9;
    start[0] = 1'b1; step(); start[0] = 1'b0;
    step(7);
    chk("cap_cnt_pre", cnt[0], 7);
    capture_in[0] = 1'b1; step();
    chk("cap_stb", {31'd0, capture_stb[0]}, 1);
    chk("cap_val", capture_val[0], 7);
    chk("cap_cnt_post", cnt[0], 8);
    step();
    chk("cap_stb_once", {31'd0, capture_stb[0]}, 0);
    chk("cap_val_hold", capture_val[0], 7);
    capture_in[0] = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
